// File: rtl/reconvolve_40mhz.sv
// rtl/reconvolve_40mhz.sv - rebuilds an exponential-tail FADC trace from a deconvolved amplitude stream
module reconvolve_40mhz #(
    parameter int ADC_WIDTH           = 12,
    parameter int BASELINE_EXTRA_BITS = 3,
    parameter int FD_BITS             = 6,
    parameter int GN_BITS             = 12,
    parameter int GN_FRAC_BITS        = 10
) (
    input  logic                                     CLK,
    input  logic                                     RESET,
    input  logic [1:0]                               ENABLE40,
    input  logic                                     CLEAR,
    input  logic [ADC_WIDTH-1:0]                     ADC_IN,
    input  logic [ADC_WIDTH+BASELINE_EXTRA_BITS-1:0] BASELINE,
    input  logic [FD_BITS-1:0]                       FD,
    input  logic [GN_BITS-1:0]                       GN,
    output logic [ADC_WIDTH-1:0]                     ADC_OUT,
    output logic                                     OUT_VALID,
    output logic                                     SAT
);

    // Accumulator: integer ADC part plus FD_BITS fractional bits.
    localparam int ACC_W  = ADC_WIDTH + FD_BITS;
    // Shift that brings the GN product from GN_FRAC_BITS down to FD_BITS fractional bits.
    localparam int SH     = GN_FRAC_BITS - FD_BITS;
    localparam int PROD_W = ADC_WIDTH + GN_BITS;
    // One spare bit so the rounding add can never wrap.
    localparam int PRND_W = PROD_W + 1;
    localparam int PA_W   = PRND_W - SH;
    localparam int QP_W   = ACC_W + FD_BITS;
    // Sum is one bit wider than the widest addend so saturation is detected exactly.
    localparam int S_W    = ((PA_W > ACC_W) ? PA_W : ACC_W) + 1;
    localparam int ARND_W = ACC_W + 1;
    localparam int R_W    = ARND_W - FD_BITS;
    localparam int T_W    = ADC_WIDTH + 2;

    localparam int RND_GN  = 1 << (SH - 1);
    localparam int RND_FD  = 1 << (FD_BITS - 1);
    localparam int ADC_MAX = (1 << ADC_WIDTH) - 1;

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    // Registered state and next-state values.
    logic [ADC_WIDTH-1:0] x_r_q,     x_r_d;
    logic [PA_W-1:0]      p_a_q,     p_a_d;
    logic [ACC_W-1:0]     q_q,       q_d;
    logic [ACC_W-1:0]     acc_q,     acc_d;
    logic                 acc_sat_q, acc_sat_d;
    logic [ADC_WIDTH-1:0] adc_out_q, adc_out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 sat_q,     sat_d;

    // Datapath intermediates.
    logic [PROD_W-1:0]    prod_xg;
    logic [PRND_W-1:0]    prod_rnd;
    logic [PA_W-1:0]      pa_calc;
    logic [QP_W-1:0]      prod_acc_fd;
    logic [ACC_W-1:0]     q_calc;
    logic [S_W-1:0]       sum_s;
    logic                 sum_sat;
    logic [ACC_W-1:0]     acc_next;
    logic [ARND_W-1:0]    acc_rnd;
    logic [R_W-1:0]       r_out;
    logic [ADC_WIDTH-1:0] base_int;
    logic [T_W-1:0]       t_sum;
    logic                 t_clip;

    // Arithmetic for all three phases; the phase decode below picks which result is stored.
    always_comb begin
        // Gain path: x*GN rounded to FD_BITS fractional bits, full width kept.
        prod_xg     = PROD_W'(x_r_q) * PROD_W'(GN);
        prod_rnd    = PRND_W'(prod_xg) + PRND_W'(RND_GN);
        pa_calc     = PA_W'(prod_rnd >> SH);

        // Feedback path: ACC*FD truncated back to FD_BITS fractional bits.
        prod_acc_fd = QP_W'(acc_q) * QP_W'(FD);
        q_calc      = ACC_W'(prod_acc_fd >> FD_BITS);

        // Recursion sum with clamp to the accumulator ceiling.
        sum_s       = S_W'(p_a_q) + S_W'(q_q);
        sum_sat     = (sum_s > S_W'(ACC_MAX));
        acc_next    = sum_sat ? ACC_MAX : ACC_W'(sum_s);

        // Output stage: round ACC to an integer, add baseline integer part, clip.
        acc_rnd     = ARND_W'(acc_q) + ARND_W'(RND_FD);
        r_out       = R_W'(acc_rnd >> FD_BITS);
        base_int    = ADC_WIDTH'(BASELINE >> BASELINE_EXTRA_BITS);
        t_sum       = T_W'(r_out) + T_W'(base_int);
        t_clip      = (t_sum > T_W'(ADC_MAX));
    end

    // Phase decode: each phase updates only its own registers; phase 3 holds everything.
    always_comb begin
        x_r_d       = x_r_q;
        p_a_d       = p_a_q;
        q_d         = q_q;
        acc_d       = acc_q;
        acc_sat_d   = acc_sat_q;
        adc_out_d   = adc_out_q;
        sat_d       = sat_q;
        out_valid_d = 1'b0;

        case (ENABLE40)
            2'd0: begin
                x_r_d       = ADC_IN;
                adc_out_d   = t_clip ? ADC_WIDTH'(ADC_MAX) : ADC_WIDTH'(t_sum);
                sat_d       = t_clip | acc_sat_q;
                out_valid_d = 1'b1;
                // Output above already used the old ACC; only the stored value is cleared.
                if (CLEAR) begin
                    acc_d     = '0;
                    acc_sat_d = 1'b0;
                end
            end
            2'd1: begin
                p_a_d = pa_calc;
                q_d   = q_calc;
            end
            2'd2: begin
                acc_d     = acc_next;
                acc_sat_d = sum_sat;
            end
            default: begin
            end
        endcase
    end

    // State register with synchronous active-high reset taking priority.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            x_r_q       <= '0;
            p_a_q       <= '0;
            q_q         <= '0;
            acc_q       <= '0;
            acc_sat_q   <= 1'b0;
            adc_out_q   <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            x_r_q       <= x_r_d;
            p_a_q       <= p_a_d;
            q_q         <= q_d;
            acc_q       <= acc_d;
            acc_sat_q   <= acc_sat_d;
            adc_out_q   <= adc_out_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign ADC_OUT   = adc_out_q;
    assign OUT_VALID = out_valid_q;
    assign SAT       = sat_q;

endmodule

// File: tb/tb_reconvolve_40mhz.sv
// tb/tb_reconvolve_40mhz.sv - directed self-checking bench for reconvolve_40mhz
module tb_reconvolve_40mhz;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  ENABLE40;
    logic        CLEAR;
    logic [11:0] ADC_IN;
    logic [14:0] BASELINE;
    logic [5:0]  FD;
    logic [11:0] GN;
    logic [11:0] ADC_OUT;
    logic        OUT_VALID;
    logic        SAT;

    int n_checks = 0;
    int n_err    = 0;

    logic [11:0] last_out;
    logic        last_sat;
    logic [2:0]  vld_pat;
    logic        hold_vld;
    logic        hold_moved;

    reconvolve_40mhz dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ENABLE40  (ENABLE40),
        .CLEAR     (CLEAR),
        .ADC_IN    (ADC_IN),
        .BASELINE  (BASELINE),
        .FD        (FD),
        .GN        (GN),
        .ADC_OUT   (ADC_OUT),
        .OUT_VALID (OUT_VALID),
        .SAT       (SAT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One 40 MHz period: phases 0,1,2. Captures the output produced at this phase 0.
    task automatic period(input logic [11:0] x, input logic clr);
        @(negedge CLK);
        vld_pat[2] = OUT_VALID;
        ENABLE40 = 2'd0;
        ADC_IN   = x;
        CLEAR    = clr;
        @(negedge CLK);
        vld_pat[1] = OUT_VALID;
        last_out   = ADC_OUT;
        last_sat   = SAT;
        ENABLE40 = 2'd1;
        CLEAR    = 1'b0;
        @(negedge CLK);
        vld_pat[0] = OUT_VALID;
        ENABLE40 = 2'd2;
    endtask

    initial begin
        RESET    = 1'b1;
        ENABLE40 = 2'd3;
        CLEAR    = 1'b0;
        ADC_IN   = '0;
        BASELINE = '0;
        FD       = '0;
        GN       = '0;
        repeat (3) @(negedge CLK);
        chk("reset_out", 32'(ADC_OUT), 0);
        chk("reset_vld", 32'(OUT_VALID), 0);
        chk("reset_sat", 32'(SAT), 0);
        RESET = 1'b0;

        // Unity passthrough
        FD = 6'd0; GN = 12'd1024; BASELINE = 15'(800 << 3);
        period(12'd100, 1'b0); chk("unity_idle", 32'(last_out), 800);
        chk("unity_vld", 32'(vld_pat), 32'b010);
        period(12'd0, 1'b0);   chk("unity_900", 32'(last_out), 900);
        chk("unity_sat", 32'(last_sat), 0);
        chk("unity_vld2", 32'(vld_pat), 32'b010);
        period(12'd0, 1'b0);   chk("unity_800", 32'(last_out), 800);

        // Exponential tail with FD=0.5
        FD = 6'd32; GN = 12'd1024; BASELINE = 15'd0;
        period(12'd100, 1'b0); chk("tail_pre", 32'(last_out), 0);
        period(12'd0, 1'b0);   chk("tail_0", 32'(last_out), 100);
        period(12'd0, 1'b0);   chk("tail_1", 32'(last_out), 50);
        period(12'd0, 1'b0);   chk("tail_2", 32'(last_out), 25);
        period(12'd0, 1'b0);   chk("tail_3", 32'(last_out), 13);
        period(12'd0, 1'b0);   chk("tail_4", 32'(last_out), 6);
        period(12'd0, 1'b0);   chk("tail_5", 32'(last_out), 3);
        period(12'd0, 1'b0);   chk("tail_6", 32'(last_out), 2);
        period(12'd0, 1'b0);   chk("tail_7", 32'(last_out), 1);
        period(12'd0, 1'b0);   chk("tail_8", 32'(last_out), 0);
        period(12'd0, 1'b0);   chk("tail_9", 32'(last_out), 0);

        // Phase-3 hold and CLEAR, baseline 200; ACC residue of 6 is cleared on entry
        BASELINE = 15'(200 << 3);
        period(12'd100, 1'b1); chk("clr_entry", 32'(last_out), 200);
        period(12'd0, 1'b0);   chk("hold_a", 32'(last_out), 300);
        period(12'd0, 1'b0);   chk("hold_b", 32'(last_out), 250);
        @(negedge CLK);
        ENABLE40   = 2'd3;
        hold_vld   = 1'b0;
        hold_moved = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            hold_vld   = hold_vld | OUT_VALID;
            hold_moved = hold_moved | (ADC_OUT != 12'd250);
        end
        chk("hold_no_vld", 32'(hold_vld), 0);
        chk("hold_frozen", 32'(hold_moved), 0);
        period(12'd0, 1'b0);   chk("hold_resume", 32'(last_out), 225);
        period(12'd0, 1'b1);   chk("clr_old_acc", 32'(last_out), 213);
        period(12'd0, 1'b0);   chk("clr_baseline", 32'(last_out), 200);

        // Accumulator saturation with GN=2.0
        FD = 6'd0; GN = 12'd2048; BASELINE = 15'd0;
        period(12'd4095, 1'b0); chk("sat_pre", 32'(last_out), 0);
        period(12'd10, 1'b0);   chk("sat_out", 32'(last_out), 4095);
        chk("sat_flag", 32'(last_sat), 1);
        period(12'd0, 1'b0);    chk("sat_20", 32'(last_out), 20);
        chk("sat_clr", 32'(last_sat), 0);

        // Clip from baseline addition; 4095 exactly is not clipped
        GN = 12'd1024; BASELINE = 15'(4000 << 3);
        period(12'd200, 1'b0); chk("bl_idle", 32'(last_out), 4000);
        chk("bl_idle_sat", 32'(last_sat), 0);
        period(12'd95, 1'b0);  chk("bl_clip", 32'(last_out), 4095);
        chk("bl_clip_sat", 32'(last_sat), 1);
        period(12'd0, 1'b0);   chk("bl_edge", 32'(last_out), 4095);
        chk("bl_edge_sat", 32'(last_sat), 0);

        // Rounding with GN=1.5: 4.5 -> 5, 1.5 -> 2
        GN = 12'd1536; BASELINE = 15'd0;
        period(12'd3, 1'b0); chk("rnd_pre", 32'(last_out), 0);
        period(12'd1, 1'b0); chk("rnd_4p5", 32'(last_out), 5);
        period(12'd0, 1'b0); chk("rnd_1p5", 32'(last_out), 2);

        // Reset asserted at phase 1 mid-tail
        FD = 6'd32; GN = 12'd1024; BASELINE = 15'(100 << 3);
        period(12'd100, 1'b0); chk("rst_pre0", 32'(last_out), 100);
        period(12'd0, 1'b0);   chk("rst_pre1", 32'(last_out), 200);
        @(negedge CLK);
        ENABLE40 = 2'd0;
        ADC_IN   = 12'd0;
        @(negedge CLK);
        chk("rst_tail", 32'(ADC_OUT), 150);
        ENABLE40 = 2'd1;
        RESET    = 1'b1;
        @(negedge CLK);
        chk("rst_mid_out", 32'(ADC_OUT), 0);
        chk("rst_mid_sat", 32'(SAT), 0);
        chk("rst_mid_vld", 32'(OUT_VALID), 0);
        RESET    = 1'b0;
        ENABLE40 = 2'd2;
        period(12'd0, 1'b0); chk("rst_post0", 32'(last_out), 100);
        period(12'd0, 1'b0); chk("rst_post1", 32'(last_out), 100);

        // Round trip of deconvolved pulses, FD=58, GN=96
        FD = 6'd58; GN = 12'd96; BASELINE = 15'd0;
        period(12'd3200, 1'b1); chk("rt_pre", 32'(last_out), 0);
        period(12'd300, 1'b0);  chk("rt_a0", 32'(last_out), 300);
        period(12'd300, 1'b0);  chk("rt_a1", 32'(last_out), 300);
        period(12'd1067, 1'b1); chk("rt_a2", 32'(last_out), 300);
        period(12'd100, 1'b0);  chk("rt_b0", 32'(last_out), 100);
        period(12'd100, 1'b0);  chk("rt_b1", 32'(last_out), 100);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/reconvolve_40mhz.md
Name: reconvolve_40mhz

Overview:
- Inverse of the FADC trace deconvolver. Rebuilds an exponential-tail FADC trace from a deconvolved amplitude stream using a first-order recursive (IIR) filter: acc[n] = GN*x[n] + FD*acc[n-1].
- The rebuilt trace is re-based onto the shower baseline and saturated to 12 bits.
- Runs on the 120 MHz clock with a 40 MHz phase enable. Each sample has three clocks for the recursive loop.
- Used for self-test round trips against the deconvolver and for synthetic-trace injection into compatibility triggers.

Parameters:
- ADC_WIDTH, 12, ADC sample width
- BASELINE_EXTRA_BITS, 3, fractional bits on BASELINE
- FD_BITS, 6, decay constant width; format .yyyyyy
- GN_BITS, 12, gain width
- GN_FRAC_BITS, 10, fractional bits of GN (xx.yyyyyyyyyy); must be > FD_BITS

Ports:
- CLK  in  1  120 MHz clock
- RESET  in  1  synchronous, active-high reset
- ENABLE40  in  2  40 MHz phase: 0,1,2 cycle; 3 is invalid
- CLEAR  in  1  synchronous accumulator clear, sampled at phase 0
- ADC_IN  in  ADC_WIDTH  deconvolved amplitude, unsigned
- BASELINE  in  ADC_WIDTH+BASELINE_EXTRA_BITS  baseline; integer part is the upper ADC_WIDTH bits
- FD  in  FD_BITS  fractional decay constant
- GN  in  GN_BITS  inverse normaliser, fixed point
- ADC_OUT  out  ADC_WIDTH  reconstructed trace sample
- OUT_VALID  out  1  one-clock pulse when ADC_OUT updates
- SAT  out  1  high when the current ADC_OUT was clipped

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RESET, and takes priority over everything else.
- Reset values: ADC_OUT=0, OUT_VALID=0, SAT=0. All internals are 0, including X_R, P_A, Q and ACC.
- Accumulator: ACC is unsigned, ADC_WIDTH+FD_BITS bits wide, with FD_BITS fractional bits. ACC_MAX is all ones.
- Phase 0:
  - X_R <= ADC_IN.
  - Output stage, using the ACC value from the previous phase 2:
    - R = (ACC + 2^(FD_BITS-1)) >> FD_BITS.
    - T = R + BASELINE integer part.
    - If T > 4095: ADC_OUT=4095, SAT=1. Else ADC_OUT=T.
    - SAT is also 1 if ACC was saturated at the last phase 2.
  - OUT_VALID=1 for this clock only.
  - If CLEAR=1: ACC <= 0. The output stage still uses the old ACC value.
- Phase 1:
  - P_A <= (X_R*GN + 2^(GN_FRAC_BITS-FD_BITS-1)) >> (GN_FRAC_BITS-FD_BITS). This rounds to FD_BITS fractional bits and is kept at full width.
  - Q <= (ACC*FD) >> FD_BITS. This truncates and leaves FD_BITS fractional bits.
- Phase 2:
  - S = P_A + Q, evaluated at full width.
  - ACC <= min(S, ACC_MAX). Record the saturation flag.
- Phase 3: every register holds, OUT_VALID=0.
- OUT_VALID is 0 on all non-phase-0 clocks.
- Latency: a sample captured at phase 0 of period n appears on ADC_OUT at phase 0 of period n+1. That is 3 clocks.
- Throughput: one sample per 40 MHz period.
- FD, GN and BASELINE are sampled at the phase that uses them. Changes take effect on the next sample and need no resync.
- FD=0 gives a pure gain path: ADC_OUT = round(GN*x) + baseline.
- GN=0 gives a decay of the existing ACC only.
- RESET mid-period: state returns to the reset values. Processing restarts at the next phase 0, with no partial-sample output.
- CLEAR together with ADC_IN at the same phase 0: the new sample is still captured, so the next output equals GN*x alone.

Test Plan:
- Unity passthrough: FD=0, GN=1024 (1.0), BASELINE=800<<3, ADC_IN=100 then 0 -> ADC_OUT=900 then 800, SAT=0, OUT_VALID once per 3 clocks.
- Exponential tail: FD=32 (0.5), GN=1024, BASELINE=0, impulse of 100 then zeros -> ADC_OUT sequence 100, 50, 25, 13, 6, 3, 2, 1, 0, 0.
- Saturation: GN=2048 (2.0), FD=0, ADC_IN=4095 -> ADC_OUT=4095, SAT=1. Then ADC_IN=10 -> 20, SAT=0.
- Phase 3 and CLEAR:
  - Mid-tail, hold ENABLE40=3 for 6 clocks -> no OUT_VALID pulses, ADC_OUT frozen, and the sequence resumes unchanged afterwards.
  - Assert CLEAR during the tail with ADC_IN=0 -> next-but-one output equals the baseline.
- Reset mid-tail: RESET asserted at phase 1 -> ADC_OUT=0 and SAT=0 on the next clock. After release, zeros in -> outputs equal the baseline with no residual tail.
- Round trip: drive the deconvolver output with FD=58 and FN≈1/(1-FD) into this block with the same FD and GN=1024/FN. Feed a 12-bit pulse library -> reconstruction within ±2 LSB of the original, after the pipeline delay.
